// File: rtl/sine_cos_pkg.sv
// Shared state encoding and oscillator constants for the sine/cos burst sequencer.
package sine_cos_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int OSC_W = 8;

    // Phase the oscillator holds while its reset is asserted.
    localparam logic [OSC_W-1:0] OSC_INIT_SINE = 8'd0;
    localparam logic [OSC_W-1:0] OSC_INIT_COS  = 8'd120;

endpackage

// File: rtl/sine_cos_rate_div.sv
// Sample-rate down-counter: ticks at zero, reloads on each oscillator step, holds at zero when stalled.
module sine_cos_rate_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             reload,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (reload) begin
            cnt_d = div;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/sine_cos_seq.sv
// Burst sequencer driving the sine/cos oscillator and a one-deep valid/ready sample register.
module sine_cos_seq
    import sine_cos_pkg::*;
#(
    parameter int DIV_W = 8,
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic             abort,
    output logic             osc_rst_n,
    output logic             osc_en,
    input  logic [OSC_W-1:0] osc_sine,
    input  logic [OSC_W-1:0] osc_cos,
    output logic             smp_valid,
    input  logic             smp_ready,
    output logic [OSC_W-1:0] smp_sine,
    output logic [OSC_W-1:0] smp_cos,
    output logic             smp_last,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    // Handshake: a sample transfers on any edge where smp_valid && smp_ready;
    // smp_* are held stable while smp_valid && !smp_ready, and a new capture
    // only happens when the register is empty or being drained that same edge.

    state_e           state_q;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] rem_q;
    logic             osc_rst_n_q;
    logic             smp_valid_q;
    logic             smp_last_q;
    logic [OSC_W-1:0] smp_sine_q;
    logic [OSC_W-1:0] smp_cos_q;
    logic             done_q;
    logic             tick;

    sine_cos_rate_div #(
        .DIV_W (DIV_W)
    ) u_rate_div (
        .clk    (clk),
        .rst_n  (reset),
        .clear  (state_q == INIT),
        .reload (osc_en),
        .div    (div_q),
        .tick   (tick)
    );

    // osc_rst_n_q is low only out of reset and during INIT, so it also gates
    // command acceptance until the first edge after reset release.
    assign cfg_ready = (state_q == IDLE) && osc_rst_n_q && !abort;
    assign osc_en    = (state_q == RUN) && tick && (!smp_valid_q || smp_ready) && !abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            div_q       <= '0;
            rem_q       <= '0;
            osc_rst_n_q <= 1'b0;
            smp_valid_q <= 1'b0;
            smp_last_q  <= 1'b0;
            smp_sine_q  <= '0;
            smp_cos_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            osc_rst_n_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (cfg_valid && cfg_ready) begin
                        div_q <= cfg_div;
                        rem_q <= cfg_len;
                        if (cfg_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q     <= INIT;
                            osc_rst_n_q <= 1'b0;
                        end
                    end
                end
                INIT: begin
                    state_q <= abort ? IDLE : RUN;
                end
                RUN: begin
                    if (abort) begin
                        state_q     <= IDLE;
                        smp_valid_q <= 1'b0;
                        smp_last_q  <= 1'b0;
                    end else if (osc_en) begin
                        smp_sine_q  <= osc_sine;
                        smp_cos_q   <= osc_cos;
                        smp_valid_q <= 1'b1;
                        smp_last_q  <= (rem_q == CNT_W'(1));
                        rem_q       <= rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_q <= DRAIN;
                        end
                    end else if (smp_valid_q && smp_ready) begin
                        smp_valid_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state_q     <= IDLE;
                        smp_valid_q <= 1'b0;
                        smp_last_q  <= 1'b0;
                    end else if (smp_valid_q && smp_ready) begin
                        state_q     <= IDLE;
                        smp_valid_q <= 1'b0;
                        smp_last_q  <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign osc_rst_n = osc_rst_n_q;
    assign smp_valid = smp_valid_q;
    assign smp_sine  = smp_sine_q;
    assign smp_cos   = smp_cos_q;
    assign smp_last  = smp_last_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: doc/sine_cos_seq.md
Name: sine_cos_seq

Overview:
Burst sequencer for the 8-bit sine/cos rotation oscillator. It accepts a burst command (sample rate divider, sample count) and drives the oscillator's reset and step enable. Each generated sine/cos pair is captured into a one-deep output register with a valid/ready handshake, and the oscillator is stalled under backpressure. It sits between the control/register interface and the tone consumer (DAC/PWM path).

Parameters:
DIV_W, 8, width of the rate divider; one step per (cfg_div+1) clocks.
CNT_W, 12, width of the burst sample counter.

Ports:
clk  in  1  single system clock.
reset  in  1  asynchronous, active-low reset.
cfg_valid  in  1  burst command valid.
cfg_ready  out  1  command accepted when cfg_valid && cfg_ready.
cfg_div  in  DIV_W  rate divider.
cfg_len  in  CNT_W  samples in burst; 0 = empty burst.
abort  in  1  cancel the active burst.
osc_rst_n  out  1  registered active-low reset to the oscillator.
osc_en  out  1  oscillator step enable.
osc_sine  in  8  oscillator sine output (next state, two's complement).
osc_cos  in  8  oscillator cos output.
smp_valid  out  1  sample valid.
smp_ready  in  1  consumer ready.
smp_sine  out  8  captured sine.
smp_cos  out  8  captured cos.
smp_last  out  1  marks the final sample of the burst.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse on burst completion.

Behaviour:
- Reset values: state=IDLE, osc_rst_n=0, and all other outputs 0. osc_rst_n rises on the first clock edge after reset deasserts.
- States: IDLE, INIT, RUN, DRAIN.
- IDLE:
  - cfg_ready = !abort.
  - On accept, latch div and len.
  - If len==0: done pulses the next cycle and the state stays IDLE.
  - Otherwise go to INIT.
- INIT: lasts exactly one cycle. osc_rst_n=0 during it, so every burst starts at phase sine=0, cos=120. Rate counter is set to 0. Next state is RUN.
- RUN:
  - tick = (rate_cnt==0).
  - osc_en = RUN && tick && (!smp_valid || smp_ready). This is combinational from registers.
  - On the osc_en edge:
    - capture osc_sine/osc_cos into smp_*;
    - set smp_valid;
    - reload rate_cnt=div;
    - decrement remaining;
    - set smp_last = (remaining==1).
  - Otherwise rate_cnt decrements while nonzero and holds at 0 while stalled.
  - After the last capture, go to DRAIN.
- Handshake:
  - smp_valid clears on smp_valid && smp_ready unless a new capture happens on the same edge.
  - Data is stable while valid && !ready.
  - With div=0 and ready held high, one sample per clock.
- DRAIN: on the last sample's handshake, clear smp_valid, pulse done for one cycle, and return to IDLE.
- Latency: accept at edge E0 → INIT in cycle 1 → first osc_en in cycle 2 → smp_valid in cycle 3.
- abort in INIT, RUN or DRAIN:
  - next edge: IDLE;
  - smp_valid and smp_last cleared;
  - osc_en low from the abort cycle onward;
  - no done pulse.
  - abort in IDLE is ignored, but it blocks cfg acceptance in that cycle.
- Oscillator arithmetic is owned by the oscillator. Sample widths are a fixed 8 bits and are passed unmodified.
- Asynchronous reset mid-burst: return to the reset values immediately. Any partial sample is lost.

Decomposition:
- Package sine_cos_pkg:
  - state enum (IDLE/INIT/RUN/DRAIN);
  - OSC_W=8;
  - OSC_INIT_SINE=0, OSC_INIT_COS=120 (for bench models).
- One natural sub-module: sine_cos_rate_div, the down-counter with reload/tick/hold. The FSM and output register stay in the top.
- The bench instantiates sine_cos_seq together with the oscillator.

Test Plan:
1. Reset, then cfg len=3, div=0, ready=1 → smp_valid in cycle 3; samples (15,119), (29,116), (43,111); smp_last on the third sample; done one cycle after the third handshake.
2. len=2, div=3, ready=1 → osc_en pulses 4 clocks apart; busy high from the cycle after accept through done.
3. len=4, div=0, ready low for 5 cycles after the first valid → smp held at (15,119), osc_en stays 0, no samples lost or duplicated; sequence resumes (29,116) after ready.
4. Two back-to-back bursts, len=2 each → the second burst again starts at (15,119), confirming INIT osc_rst_n=0 pulse.
5. abort during RUN after 1 of 5 samples → IDLE the next cycle, smp_valid=0, no done; a new cfg is accepted next cycle.
6. cfg len=0 → no osc_en and no smp_valid, done pulse the cycle after accept. cfg_valid held high together with abort in IDLE → not accepted.
